seq_signed_divider: RTL and testbench

- Multicycle 32-bit signed integer divider for the multdiv path of the processor.
- Converts operands to magnitudes and runs one restoring shift-subtract step per cycle.
- Then re-applies signs to the quotient by two's-complement negation.
- Sits beside the ALU and is launched by a one-cycle ctrl_DIV pulse from the execute stage; the pipeline stalls until data_resultRDY.

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_signed_divider_twos_negate.sv | 15 +
 rtl/seq_signed_divider.sv | 155 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [WIDTH_DEF-1:0] DIV_ZERO_RESULT = {WIDTH_DEF{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_twos_negate.sv
// Combinational conditional two's-complement negate: inverter plus incrementer.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] inv_s;

  assign inv_s = in ^ {WIDTH{neg}};
  assign out   = inv_s + {{(WIDTH-1){1'b0}}, neg};

endmodule

// File: rtl/seq_signed_divider.sv
// Multicycle signed divider, one restoring step per cycle, quotient truncated toward zero.
// Optional remainder output enabled by defining SEQ_DIV_REMAINDER_EN.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef SEQ_DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_quo_q, neg_quo_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] abs_a_s, abs_b_s, quo_signed_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] rem_sub_s;
  logic             sub_ok_s;

  twos_negate #(.WIDTH(WIDTH)) u_abs_a (.in(data_operandA), .neg(data_operandA[WIDTH-1]), .out(abs_a_s));
  twos_negate #(.WIDTH(WIDTH)) u_abs_b (.in(data_operandB), .neg(data_operandB[WIDTH-1]), .out(abs_b_s));
  twos_negate #(.WIDTH(WIDTH)) u_fix_q (.in(quo_q), .neg(neg_quo_q), .out(quo_signed_s));

`ifdef SEQ_DIV_REMAINDER_EN
  logic             neg_a_q, neg_a_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [WIDTH-1:0] rem_signed_s;

  twos_negate #(.WIDTH(WIDTH)) u_fix_r (.in(rem_q), .neg(neg_a_q), .out(rem_signed_s));
  assign data_remainder = remainder_q;
`endif

  // The restored remainder is always below |B|, so the top bit is only needed for the compare.
  assign rem_shift_s = {rem_q, quo_q[WIDTH-1]};
  assign sub_ok_s    = (rem_shift_s >= {1'b0, mag_b_q});
  assign rem_sub_s   = rem_shift_s[WIDTH-1:0] - mag_b_q;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quo_q      <= {WIDTH{1'b0}};
      mag_b_q    <= {WIDTH{1'b0}};
      neg_quo_q  <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= {WIDTH{1'b0}};
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
      neg_a_q     <= 1'b0;
      remainder_q <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      mag_b_q    <= mag_b_d;
      neg_quo_q  <= neg_quo_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
`ifdef SEQ_DIV_REMAINDER_EN
      neg_a_q     <= neg_a_d;
      remainder_q <= remainder_d;
`endif
    end
  end

  // Next-state: a start pulse restarts from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ctrl_DIV ? ITER : IDLE;
      ITER:    state_d = ctrl_DIV ? ITER : ((cnt_q == LAST_CNT) ? FIX : ITER);
      FIX:     state_d = ctrl_DIV ? ITER : DONE;
      DONE:    state_d = ctrl_DIV ? ITER : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    mag_b_d    = mag_b_q;
    neg_quo_d  = neg_quo_q;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    exc_d      = exc_q;
    rdy_d      = 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
    neg_a_d     = neg_a_q;
    remainder_d = remainder_q;
`endif
    if (ctrl_DIV) begin
      cnt_d      = {CNT_W{1'b0}};
      rem_d      = {WIDTH{1'b0}};
      quo_d      = abs_a_s;
      mag_b_d    = abs_b_s;
      neg_quo_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero_d = (data_operandB == {WIDTH{1'b0}});
`ifdef SEQ_DIV_REMAINDER_EN
      neg_a_d    = data_operandA[WIDTH-1];
`endif
    end else begin
      case (state_q)
        ITER: begin
          rem_d = sub_ok_s ? rem_sub_s : rem_shift_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], sub_ok_s};
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          result_d = div_zero_q ? WIDTH'(DIV_ZERO_RESULT) : quo_signed_s;
          exc_d    = div_zero_q;
          rdy_d    = 1'b1;
`ifdef SEQ_DIV_REMAINDER_EN
          remainder_d = div_zero_q ? {WIDTH{1'b0}} : rem_signed_s;
`endif
        end
        default: ;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider (remainder checks when SEQ_DIV_REMAINDER_EN).
module tb_seq_signed_divider;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef SEQ_DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  seq_signed_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef SEQ_DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse a start, measure edges to RDY, check outputs and that RDY lasts one cycle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic exp_exc, input logic [31:0] exp_rem);
    int lat;
    lat = -1;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) begin
        lat = n;
        break;
      end
    end
    check_val({tag, "_latency"}, 32'(lat), 32'd33);
    check_val({tag, "_result"}, data_result, exp_q);
    check_val({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
`ifdef SEQ_DIV_REMAINDER_EN
    check_val({tag, "_rem"}, data_remainder, exp_rem);
`else
    if (exp_rem === 32'hDEAD_BEEF) $display("note: unexpected remainder marker");
`endif
    @(negedge clock);
    check_val({tag, "_rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  // Count RDY pulses over a window; callers expect none.
  task automatic watch_no_rdy(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    check_val(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("reset_result", data_result, 32'd0);
    check_val("reset_exc", {31'd0, data_exception}, 32'd0);
    check_val("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    watch_no_rdy("idle_no_rdy", 10);

    run_div("p100_p7", 32'd100, 32'd7, 32'h0000_000E, 1'b0, 32'd2);
    run_div("m100_p7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE);
    run_div("m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, 32'hFFFF_FFFE);
    run_div("m7_p2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF);
    run_div("p7_p100", 32'd7, 32'd100, 32'd0, 1'b0, 32'd7);
    run_div("div_zero", 32'd55, 32'd0, 32'd0, 1'b1, 32'd0);
    run_div("after_zero", 32'd9, 32'd3, 32'd3, 1'b0, 32'd0);
    run_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd0);
    run_div("min_p1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 32'd0);
    run_div("zero_m5", 32'd0, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'd0);

    // Restart mid-operation: only the second division may complete.
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    watch_no_rdy("abort_window", 9);
    run_div("restart_81_9", 32'd81, 32'd9, 32'd9, 1'b0, 32'd0);
    watch_no_rdy("after_restart_quiet", 40);

    // Reset mid-operation: no RDY, outputs cleared, next division normal.
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("midreset_result", data_result, 32'd0);
    check_val("midreset_exc", {31'd0, data_exception}, 32'd0);
    watch_no_rdy("midreset_no_rdy", 40);
    run_div("post_reset", 32'd100, 32'd7, 32'h0000_000E, 1'b0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
